fps_packet_receiver: RTL and testbench

- Mitigation-node end of the clockwise fast-protect link.
- Consumes the 16-bit Aurora AXI stream built by acquisition nodes' local-packet generators and validates each packet's framing.
- Deserialises the payload into one DATA_WIDTH-bit word and reports it with the source node ID.
- Keeps saturating error and packet statistics for the processor GPIO/register interface.

---
 rtl/fps_packet_pkg.sv | 20 ++
 rtl/fps_sat_counter.sv | 33 +++
 rtl/fps_packet_receiver.sv | 205 ++++++++++++++++++++
 tb/tb_fps_packet_receiver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fps_packet_pkg.sv
// Shared types and constants for the fast-protect packet receiver.
// Used by both default and FPS_PACKET_CHECKSUM_EN builds.
package fps_packet_pkg;

  localparam logic [3:0] HEADER_MAGIC   = 4'hA;
  localparam int         CHECKSUM_WIDTH = 16;

  typedef enum logic [2:0] {
    HEADER,
    PAYLOAD,
    CHECKSUM,
    DISCARD,
    ACCEPT
  } state_e;

  function automatic int payload_words(input int data_width);
    return data_width / 16;
  endfunction

endpackage

// File: rtl/fps_sat_counter.sv
// Saturating statistics counter; clear wins over a coincident increment.
module fps_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fps_packet_receiver.sv
// Fast-protect link receiver: frames, deserialises and counts Aurora packets.
// Define FPS_PACKET_CHECKSUM_EN to require a trailing zero-sum checksum word.
module fps_packet_receiver
  import fps_packet_pkg::*;
#(
  parameter int DATA_WIDTH     = 160,
  parameter int NODE_ID_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [15:0]              incomingTDATA,
  input  logic                     incomingTVALID,
  input  logic                     incomingTLAST,
  output logic [DATA_WIDTH-1:0]    rxData,
  output logic [NODE_ID_WIDTH-1:0] rxNodeId,
  output logic                     rxValid,
  output logic                     rxToggle,
  output logic [COUNTER_WIDTH-1:0] packetCount,
  output logic [COUNTER_WIDTH-1:0] headerErrors,
  output logic [COUNTER_WIDTH-1:0] lengthErrors,
  output logic [COUNTER_WIDTH-1:0] timeoutErrors,
  output logic [COUNTER_WIDTH-1:0] checksumErrors,
  input  logic                     clearCounters
);

  localparam int PAYLOAD_WORDS = payload_words(DATA_WIDTH);
  localparam int WC_W          = $clog2(PAYLOAD_WORDS + 1);
  localparam int IDLE_W        = $clog2(TIMEOUT_CYCLES + 1);

  state_e                   state_q, state_d;
  logic [WC_W-1:0]          word_cnt_q, word_cnt_d;
  logic [IDLE_W-1:0]        idle_q, idle_d;
  logic [NODE_ID_WIDTH-1:0] node_q, node_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic                     accept_q, accept_d;
  logic [DATA_WIDTH-1:0]    rx_data_q, rx_data_d;
  logic [NODE_ID_WIDTH-1:0] rx_node_q, rx_node_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     rx_toggle_q, rx_toggle_d;
  logic                     hdr_inc, len_inc, to_inc, cks_inc;
  logic                     last_word, timed_out;
`ifdef FPS_PACKET_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] sum_q, sum_d;
`endif

  assign last_word = (word_cnt_q == WC_W'(PAYLOAD_WORDS - 1));
  assign timed_out = !incomingTVALID && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    idle_d     = incomingTVALID ? '0 : idle_q + IDLE_W'(1);
    node_d     = node_q;
    shift_d    = shift_q;
    accept_d   = 1'b0;
    hdr_inc    = 1'b0;
    len_inc    = 1'b0;
    to_inc     = 1'b0;
    cks_inc    = 1'b0;
`ifdef FPS_PACKET_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      HEADER: begin
        idle_d = '0;
        if (incomingTVALID) begin
          if (incomingTDATA[15:12] != HEADER_MAGIC) begin
            hdr_inc = 1'b1;
            if (!incomingTLAST) state_d = DISCARD;
          end else if (incomingTLAST) begin
            len_inc = 1'b1;
          end else begin
            node_d     = incomingTDATA[NODE_ID_WIDTH-1:0];
            word_cnt_d = '0;
            state_d    = PAYLOAD;
`ifdef FPS_PACKET_CHECKSUM_EN
            sum_d      = incomingTDATA;
`endif
          end
        end
      end
      PAYLOAD: begin
        if (incomingTVALID) begin
          shift_d    = DATA_WIDTH'({shift_q, incomingTDATA});
          word_cnt_d = word_cnt_q + WC_W'(1);
`ifdef FPS_PACKET_CHECKSUM_EN
          sum_d      = sum_q + incomingTDATA;
          if (incomingTLAST) begin
            len_inc = 1'b1;
            state_d = HEADER;
          end else if (last_word) begin
            state_d = CHECKSUM;
          end
`else
          if (incomingTLAST && !last_word) begin
            len_inc = 1'b1;
            state_d = HEADER;
          end else if (last_word && !incomingTLAST) begin
            len_inc = 1'b1;
            state_d = DISCARD;
          end else if (last_word) begin
            state_d = ACCEPT;
          end
`endif
        end
      end
`ifdef FPS_PACKET_CHECKSUM_EN
      CHECKSUM: begin
        if (incomingTVALID) begin
          if (!incomingTLAST) begin
            len_inc = 1'b1;
            state_d = DISCARD;
          end else if ((sum_q + incomingTDATA) != '0) begin
            cks_inc = 1'b1;
            state_d = HEADER;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
`endif
      DISCARD: begin
        if (incomingTVALID && incomingTLAST) state_d = HEADER;
      end
      ACCEPT: begin
        // Any beat seen here is dropped; the link guarantees an idle gap.
        idle_d   = '0;
        accept_d = 1'b1;
        state_d  = HEADER;
      end
      default: begin
        idle_d  = '0;
        state_d = HEADER;
      end
    endcase

    if ((state_q == PAYLOAD || state_q == DISCARD || state_q == CHECKSUM) && timed_out) begin
      to_inc  = 1'b1;
      idle_d  = '0;
      state_d = HEADER;
    end

    // Outputs update one cycle after ACCEPT, giving the fixed two-cycle latency.
    rx_data_d   = accept_q ? shift_q : rx_data_q;
    rx_node_d   = accept_q ? node_q : rx_node_q;
    rx_valid_d  = accept_q;
    rx_toggle_d = rx_toggle_q ^ accept_q;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= HEADER;
      word_cnt_q  <= '0;
      idle_q      <= '0;
      node_q      <= '0;
      shift_q     <= '0;
      accept_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_node_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_toggle_q <= 1'b0;
`ifdef FPS_PACKET_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      idle_q      <= idle_d;
      node_q      <= node_d;
      shift_q     <= shift_d;
      accept_q    <= accept_d;
      rx_data_q   <= rx_data_d;
      rx_node_q   <= rx_node_d;
      rx_valid_q  <= rx_valid_d;
      rx_toggle_q <= rx_toggle_d;
`ifdef FPS_PACKET_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rxData   = rx_data_q;
  assign rxNodeId = rx_node_q;
  assign rxValid  = rx_valid_q;
  assign rxToggle = rx_toggle_q;

  fps_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_packet_cnt (
    .clk(clk), .aresetn(aresetn), .inc(accept_q), .clr(clearCounters), .count(packetCount)
  );
  fps_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_header_cnt (
    .clk(clk), .aresetn(aresetn), .inc(hdr_inc), .clr(clearCounters), .count(headerErrors)
  );
  fps_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_length_cnt (
    .clk(clk), .aresetn(aresetn), .inc(len_inc), .clr(clearCounters), .count(lengthErrors)
  );
  fps_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_timeout_cnt (
    .clk(clk), .aresetn(aresetn), .inc(to_inc), .clr(clearCounters), .count(timeoutErrors)
  );
  fps_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_checksum_cnt (
    .clk(clk), .aresetn(aresetn), .inc(cks_inc), .clr(clearCounters), .count(checksumErrors)
  );

endmodule

// File: tb/tb_fps_packet_receiver.sv
// Scoreboard bench for fps_packet_receiver in its default (no checksum) build.
module tb_fps_packet_receiver;

  localparam int DW = 160;
  localparam int NW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [15:0]   incomingTDATA = '0;
  logic          incomingTVALID = 1'b0;
  logic          incomingTLAST = 1'b0;
  logic          clearCounters = 1'b0;
  logic [DW-1:0] rxData;
  logic [NW-1:0] rxNodeId;
  logic          rxValid;
  logic          rxToggle;
  logic [CW-1:0] packetCount, headerErrors, lengthErrors, timeoutErrors, checksumErrors;

  fps_packet_receiver dut (
    .clk(clk), .aresetn(aresetn),
    .incomingTDATA(incomingTDATA), .incomingTVALID(incomingTVALID), .incomingTLAST(incomingTLAST),
    .rxData(rxData), .rxNodeId(rxNodeId), .rxValid(rxValid), .rxToggle(rxToggle),
    .packetCount(packetCount), .headerErrors(headerErrors), .lengthErrors(lengthErrors),
    .timeoutErrors(timeoutErrors), .checksumErrors(checksumErrors),
    .clearCounters(clearCounters)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DW-1:0] data;
    logic [NW-1:0] node;
    longint        due;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int            expPkt = 0, expHdr = 0, expLen = 0, expTo = 0;
  logic          expToggle = 1'b0;
  logic [DW-1:0] lastData = '0;
  logic [NW-1:0] lastNode = '0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Monitor: every rxValid strobe must match the oldest outstanding good packet.
  always @(negedge clk) begin
    if (rxValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected rxValid", DW'(rxValid), '0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("rxData", rxData, monE.data);
        checkOutput("rxNodeId", DW'(rxNodeId), DW'(monE.node));
        checkOutput("rxValid cycle", DW'(cyc), DW'(monE.due));
      end
    end
  end

  task automatic sendBeat(input logic [15:0] data, input logic last);
    @(negedge clk);
    incomingTVALID = 1'b1;
    incomingTDATA  = data;
    incomingTLAST  = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      incomingTVALID = 1'b0;
      incomingTLAST  = 1'b0;
    end
  endtask

  // Header, nwords payload words base+i, TLAST on the last; optional gap before word gapAt.
  task automatic applyStimulus(input logic [15:0] hdr, input int nwords, input logic [15:0] base,
                               input int gapAt, input int gap, input bit complete);
    logic [DW-1:0] d;
    bit good;
    good = (hdr[15:12] == 4'hA) && (nwords == 10) && complete;
    d = '0;
    sendBeat(hdr, 1'b0);
    for (int i = 0; i < nwords; i++) begin
      if (i == gapAt) begin
        idle(gap);
        if (!complete) break;
      end
      sendBeat(base + 16'(i), i == nwords - 1);
      d = {d[DW-17:0], base + 16'(i)};
    end
    if (good) begin
      expQ.push_back('{data: d, node: hdr[NW-1:0], due: cyc + 3});
      lastData  = d;
      lastNode  = hdr[NW-1:0];
      expPkt++;
      expToggle = ~expToggle;
    end
    idle(4);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " packetCount"}, DW'(packetCount), DW'(expPkt));
    checkOutput({tag, " headerErrors"}, DW'(headerErrors), DW'(expHdr));
    checkOutput({tag, " lengthErrors"}, DW'(lengthErrors), DW'(expLen));
    checkOutput({tag, " timeoutErrors"}, DW'(timeoutErrors), DW'(expTo));
    checkOutput({tag, " checksumErrors"}, DW'(checksumErrors), '0);
    checkOutput({tag, " rxToggle"}, DW'(rxToggle), DW'(expToggle));
    checkOutput({tag, " held rxData"}, rxData, lastData);
    checkOutput({tag, " held rxNodeId"}, DW'(rxNodeId), DW'(lastNode));
  endtask

  task automatic clearExpected();
    expPkt = 0; expHdr = 0; expLen = 0; expTo = 0;
    expToggle = 1'b0;
    lastData = '0;
    lastNode = '0;
  endtask

  initial begin
    #1200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset rxValid", DW'(rxValid), '0);
    checkCounters("reset");
    aresetn = 1'b1;
    idle(2);

    applyStimulus(16'hA005, 10, 16'h0001, -1, 0, 1'b1);
    checkCounters("good");

    applyStimulus(16'hA007, 7, 16'h0050, -1, 0, 1'b1);
    expLen = 1;
    checkCounters("short");
    applyStimulus(16'hA003, 10, 16'h0100, -1, 0, 1'b1);
    checkCounters("after short");

    applyStimulus(16'hA009, 12, 16'h0150, -1, 0, 1'b1);
    expLen = 2;
    checkCounters("long");
    applyStimulus(16'hA00C, 10, 16'h0200, -1, 0, 1'b1);
    checkCounters("after long");

    applyStimulus(16'h5005, 10, 16'h0250, -1, 0, 1'b1);
    expHdr = 1;
    checkCounters("bad magic");

    applyStimulus(16'hA011, 10, 16'h0300, 4, 63, 1'b1);
    checkCounters("gap 63");
    applyStimulus(16'hA012, 10, 16'h0350, 4, 64, 1'b0);
    expTo = 1;
    checkCounters("gap 64");
    applyStimulus(16'hA013, 10, 16'h0400, -1, 0, 1'b1);
    checkCounters("after timeout");

    sendBeat(16'hA020, 1'b0);
    sendBeat(16'h0501, 1'b0);
    sendBeat(16'h0502, 1'b0);
    @(negedge clk);
    incomingTVALID = 1'b0;
    aresetn = 1'b0;
    @(negedge clk);
    clearExpected();
    checkOutput("mid reset rxValid", DW'(rxValid), '0);
    checkCounters("mid reset");
    aresetn = 1'b1;
    idle(2);
    applyStimulus(16'hA021, 10, 16'h0600, -1, 0, 1'b1);
    checkCounters("after reset");

    for (int i = 0; i < 70000; i++) begin
      sendBeat(16'h5005, 1'b1);
      if (expHdr < 65535) expHdr++;
    end
    idle(2);
    checkCounters("saturated");

    @(negedge clk);
    clearCounters  = 1'b1;
    incomingTVALID = 1'b1;
    incomingTDATA  = 16'h5005;
    incomingTLAST  = 1'b1;
    @(negedge clk);
    clearCounters  = 1'b0;
    incomingTVALID = 1'b0;
    incomingTLAST  = 1'b0;
    expPkt = 0; expHdr = 0; expLen = 0; expTo = 0;
    checkCounters("clear with error");
    sendBeat(16'h5006, 1'b1);
    idle(2);
    expHdr = 1;
    checkCounters("after clear");

    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", DW'(expQ.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
